ctrl_seq: RTL
=============

# ctrl_seq

Parametrised multi-cycle control sequencer for the accumulator CPU, successor to the fixed four-phase controller. It drives the FETCH/DECODE/EXECUTE/WRITEBACK cycle with generic opcode width and ready-handshaked instruction and data memories (variable wait states). It adds a bounded wait-state watchdog, a latched HALTED state with resume, and single-step mode. It sits between the instruction/data memories, PC, and accumulator datapath.

## Interface
Parameters:
- OPW, 3, opcode width (≥3); opcodes ≥8 decode as NOP
- WAIT_LIMIT, 15, max wait cycles per memory access before timeout (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- opcode  in  OPW  instruction opcode, valid while ins_ready=1 in FETCH
- is_zero  in  1  accumulator zero flag, sampled in DECODE
- ins_ready  in  1  instruction memory read complete
- da_ready  in  1  data memory access complete
- run  in  1  resume pulse, honoured only in HALTED
- step_en  in  1  single-step mode
- pc_en  out  1  PC increment
- pc_load  out  1  PC load from instruction address field
- jmp  out  1  current instruction is JMP
- mem_ins_en  out  1  instruction memory request
- mem_da_en  out  1  data memory request
- mem_da_we  out  1  data memory write
- acc_load  out  1  accumulator write enable
- acc_sel  out  1  accumulator source: 1 = memory, 0 = ALU
- halted  out  1  sequencer in HALTED
- timeout_err  out  1  sticky watchdog error
- phase  out  3  current state encoding

## Operation
- Opcode map: 0 HLT, 1 NOP, 2 SKZ, 3 ADD, 4 AND, 5 LDA, 6 STO, 7 JMP. Opcodes ≥8 are NOP.
- ACC-writing ops: SKZ, ADD, AND, LDA (2–5). acc_sel=1 only for LDA. STO writes memory. Skip taken when SKZ and is_zero.
- States: FETCH(0), DECODE(1), EXEC(2), WB(3), HALTED(4).
- FETCH:
  - mem_ins_en=1.
  - Stays until ins_ready. On ins_ready: opcode latched into internal op register; next state DECODE.
- DECODE:
  - pc_en=1 for one cycle.
  - pc_load=1 if op=JMP or (op=SKZ and is_zero). This overrides pc_en (pc_en=0 that cycle).
  - Next state: HALTED if op=HLT, else EXEC.
- EXEC:
  - mem_da_en=1 for LDA/ADD/AND/STO; mem_da_we=1 for STO.
  - For these ops, stays until da_ready. Other ops advance after one cycle.
  - Next state WB.
- WB:
  - acc_load=1 for ops 2–5; acc_sel per op.
  - Next state: HALTED if step_en, else FETCH.
- HALTED:
  - All strobes 0, halted=1.
  - run=1 → FETCH. run and rst together → reset wins.
- jmp = (op==JMP) in DECODE, EXEC, WB; 0 in FETCH and HALTED.
- Watchdog:
  - Counter clears on every state change.
  - Increments each cycle spent waiting in FETCH or EXEC.
  - When count reaches WAIT_LIMIT with ready still low: timeout_err set (sticky), next state HALTED.
  - A ready arriving in the same cycle the limit is reached wins; no error.
- run does not clear timeout_err; only rst does.
- Reset values: state FETCH, op 0, counter 0, timeout_err 0. All strobes 0 except mem_ins_en=1 (FETCH outputs). halted=0, phase=0.

## Timing
- All outputs are Moore decodes of state plus latched op; is_zero gates pc_load combinationally in DECODE only.
- Minimum instruction latency: 4 cycles (zero wait states). Each wait cycle adds 1.
- ins_ready/da_ready are sampled on the rising clk edge; a ready outside the waiting state is ignored.
- rst asserted mid-access: next edge returns to FETCH; any pending memory request drops at that edge.
- HALT: reaches HALTED 2 cycles after ins_ready (DECODE, then HALTED). run resumes FETCH on the next edge.
- Timeout: HALTED entered on the edge after WAIT_LIMIT wait cycles.

## Structure
- Package ctrl_pkg holds:
  - state enum (ctrl_state_e, 3-bit)
  - opcode localparams (OP_HLT … OP_JMP)
  - helper function is_acc_op(op)
- Sub-module ctrl_wait_timer: counter of width $clog2(WAIT_LIMIT+1), with clear/enable inputs and an expired output.

## Test plan
- Sequence LDA, ADD, STO, JMP with ready tied high → each instruction takes 4 cycles. acc_load/acc_sel/mem_da_we/pc_load asserted exactly in their specified cycles.
- SKZ with is_zero=1, then SKZ with is_zero=0 → pc_load=1/pc_en=0 for the first; pc_en=1/pc_load=0 for the second. acc_load=1 in WB for both.
- LDA with da_ready delayed 3 cycles → EXEC held 4 cycles, instruction takes 7 cycles. No timeout_err.
- WAIT_LIMIT=15 with ins_ready never asserted → timeout_err=1 and halted=1 after 15 wait cycles. run → FETCH with timeout_err still 1. rst → timeout_err=0.
- HLT, then run pulse; step_en=1 over two ADDs → halted after each WB. Each run pulse advances exactly one instruction.
- rst asserted during EXEC wait → next cycle phase=0, mem_ins_en=1, mem_da_en=0, counter=0.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// ctrl_pkg: shared definitions for the accumulator-CPU control sequencer.
//   ctrl_state_e : sequencer state encoding (also driven out on ctrl_seq.phase)
//   OP_*         : normalised 3-bit opcode values
//   is_acc_op()  : instruction writes the accumulator
//   is_mem_op()  : instruction performs a data-memory access in EXEC
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALTED = 3'd4
   } ctrl_state_e;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_NOP = 3'd1;
   localparam logic [2:0] OP_SKZ = 3'd2;
   localparam logic [2:0] OP_ADD = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   function automatic logic is_acc_op(input logic [2:0] op);
      return (op == OP_SKZ) || (op == OP_ADD) || (op == OP_AND) || (op == OP_LDA);
   endfunction

   function automatic logic is_mem_op(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_LDA) || (op == OP_STO);
   endfunction

endpackage

// File: rtl/ctrl_seq_wait_timer.sv
// ctrl_wait_timer: wait-state watchdog counter for the control sequencer.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear the count (sequencer is changing state)
//   en       : current cycle is a wait cycle (ready still low)
//   expired  : this wait cycle is the WAIT_LIMIT-th one in the current state
module ctrl_wait_timer #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

   // Number of wait cycles already spent in the current state.
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Expiry forces a state change, so the count never runs past LAST.
   assign expired = en && (cnt == LAST);

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle FETCH/DECODE/EXEC/WB sequencer for the accumulator CPU,
// with ready-handshaked memories, a wait-state watchdog, a latched HALTED state
// and single-step mode.
//   clk, rst              : clock, synchronous active-high reset
//   opcode                : instruction opcode, valid with ins_ready in FETCH
//   is_zero               : accumulator zero flag, used in DECODE
//   ins_ready, da_ready   : instruction / data memory access complete
//   run                   : resume pulse from HALTED
//   step_en               : single-step mode (halt after every WB)
//   pc_en, pc_load, jmp   : PC control
//   mem_ins_en            : instruction memory request
//   mem_da_en, mem_da_we  : data memory request / write
//   acc_load, acc_sel     : accumulator write enable / source (1 = memory)
//   halted, timeout_err   : HALTED indication, sticky watchdog error
//   phase                 : current state encoding
module ctrl_seq #(
   parameter int OPW        = 3,
   parameter int WAIT_LIMIT = 15
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic           is_zero,
   input  logic           ins_ready,
   input  logic           da_ready,
   input  logic           run,
   input  logic           step_en,
   output logic           pc_en,
   output logic           pc_load,
   output logic           jmp,
   output logic           mem_ins_en,
   output logic           mem_da_en,
   output logic           mem_da_we,
   output logic           acc_load,
   output logic           acc_sel,
   output logic           halted,
   output logic           timeout_err,
   output logic [2:0]     phase
);

   import ctrl_pkg::*;

   ctrl_state_e state_q;
   ctrl_state_e state_d;
   logic [2:0]  op_q;
   logic [2:0]  op_norm;
   logic        wait_en;
   logic        wd_expired;

   // Opcodes beyond the defined map are folded to NOP before latching, so the
   // rest of the sequencer only ever sees a 3-bit opcode.
   assign op_norm = (32'(opcode) > 32'd7) ? OP_NOP : opcode[2:0];

   assign wait_en = ((state_q == ST_FETCH) && !ins_ready) ||
                    ((state_q == ST_EXEC) && is_mem_op(op_q) && !da_ready);

   ctrl_wait_timer #(
      .WAIT_LIMIT(WAIT_LIMIT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_d != state_q),
      .en      (wait_en),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FETCH;
         op_q        <= OP_HLT;
         timeout_err <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_FETCH) && ins_ready) begin
            op_q <= op_norm;
         end
         if (wd_expired) begin
            timeout_err <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (ins_ready) begin
               state_d = ST_DECODE;
            end else if (wd_expired) begin
               state_d = ST_HALTED;
            end
         end
         ST_DECODE: begin
            state_d = (op_q == OP_HLT) ? ST_HALTED : ST_EXEC;
         end
         ST_EXEC: begin
            if (!is_mem_op(op_q) || da_ready) begin
               state_d = ST_WB;
            end else if (wd_expired) begin
               state_d = ST_HALTED;
            end
         end
         ST_WB: begin
            state_d = step_en ? ST_HALTED : ST_FETCH;
         end
         ST_HALTED: begin
            if (run) begin
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_comb begin
      pc_en      = 1'b0;
      pc_load    = 1'b0;
      jmp        = 1'b0;
      mem_ins_en = 1'b0;
      mem_da_en  = 1'b0;
      mem_da_we  = 1'b0;
      acc_load   = 1'b0;
      acc_sel    = 1'b0;
      halted     = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_ins_en = 1'b1;
         end
         ST_DECODE: begin
            // A taken jump or skip loads the PC instead of incrementing it.
            pc_load = (op_q == OP_JMP) || ((op_q == OP_SKZ) && is_zero);
            pc_en   = !pc_load;
            jmp     = (op_q == OP_JMP);
         end
         ST_EXEC: begin
            mem_da_en = is_mem_op(op_q);
            mem_da_we = (op_q == OP_STO);
            jmp       = (op_q == OP_JMP);
         end
         ST_WB: begin
            acc_load = is_acc_op(op_q);
            acc_sel  = (op_q == OP_LDA);
            jmp      = (op_q == OP_JMP);
         end
         ST_HALTED: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign phase = state_q;

endmodule
